// File: rtl/rn_inject_queue.sv
// rn_inject_queue
//   Requester-node injection stage. Flits from the RN protocol agent are
//   buffered in a small FIFO. The FIFO head goes combinationally to the SAM
//   stage; the SAM-rewritten flit and its decode come back and are registered
//   into the router local input port when a credit is available.
//
// Ports
//   clk, rstn         clock, synchronous active-low reset
//   rn_flit_v_i/_i    flit from the RN agent; accepted when rn_flit_rdy_o=1
//   rn_flit_rdy_o     FIFO not full
//   sam_flit_v_o/_o   FIFO head (valid when non-empty) toward the SAM
//   sam_flit_i        SAM-rewritten head flit
//   sam_flit_dec_i    SAM decode of the head flit
//   tx_flit_v_o       one-cycle valid into the router local port
//   tx_flit_o         registered flit toward the router
//   tx_flit_dec_o     registered decode toward the router
//   tx_credit_rtn_i   router freed one local-port buffer entry
//   fifo_cnt_o        FIFO occupancy
//   credit_cnt_o      router credits currently available
//   credit_err_o      sticky: credit returned while already at full credit

module rn_inject_queue #(
  parameter type flit_payload_t = logic [255:0],
  parameter type flit_dec_t     = logic [15:0],
  parameter int  FIFO_DEPTH     = 4,
  parameter int  ROUTER_CREDIT  = 4,
  parameter int  FIFO_CNT_W     = $clog2(FIFO_DEPTH + 1),
  parameter int  CRED_CNT_W     = $clog2(ROUTER_CREDIT + 1)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  rn_flit_v_i,
  input  flit_payload_t         rn_flit_i,
  output logic                  rn_flit_rdy_o,
  output logic                  sam_flit_v_o,
  output flit_payload_t         sam_flit_o,
  input  flit_payload_t         sam_flit_i,
  input  flit_dec_t             sam_flit_dec_i,
  output logic                  tx_flit_v_o,
  output flit_payload_t         tx_flit_o,
  output flit_dec_t             tx_flit_dec_o,
  input  logic                  tx_credit_rtn_i,
  output logic [FIFO_CNT_W-1:0] fifo_cnt_o,
  output logic [CRED_CNT_W-1:0] credit_cnt_o,
  output logic                  credit_err_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  // Parameter sanity, caught at elaboration.
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("rn_inject_queue: FIFO_DEPTH must be a power of two >= 2");
  end
  if (ROUTER_CREDIT < 1) begin : g_bad_credit
    $error("rn_inject_queue: ROUTER_CREDIT must be >= 1");
  end

  flit_payload_t           mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [FIFO_CNT_W-1:0]   cnt_q, cnt_d;
  logic [CRED_CNT_W-1:0]   cred_q, cred_d;
  logic                    tx_v_q, tx_v_d;
  flit_payload_t           tx_flit_q, tx_flit_d;
  flit_dec_t               tx_dec_q, tx_dec_d;
  logic                    err_q, err_d;

  logic full_s, empty_s, push_s, pop_s, ovf_s, rtn_ok_s;

  // Handshake decode; ready depends only on registered occupancy, so a pop
  // in the same cycle never frees room for a push into a full FIFO.
  always_comb begin
    full_s   = (cnt_q == FIFO_CNT_W'(FIFO_DEPTH));
    empty_s  = (cnt_q == {FIFO_CNT_W{1'b0}});
    push_s   = rn_flit_v_i & ~full_s;
    pop_s    = ~empty_s & (cred_q != {CRED_CNT_W{1'b0}});
    // A return at full credit with no pop has nowhere to go: drop and flag it.
    ovf_s    = tx_credit_rtn_i & (cred_q == CRED_CNT_W'(ROUTER_CREDIT)) & ~pop_s;
    rtn_ok_s = tx_credit_rtn_i & ~ovf_s;
  end

  // Next-state for pointers, occupancy, credits, tx register and error flag.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    cred_d    = cred_q;
    tx_v_d    = 1'b0;
    tx_flit_d = tx_flit_q;
    tx_dec_d  = tx_dec_q;
    err_d     = err_q | ovf_s;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      tx_v_d    = 1'b1;
      tx_flit_d = sam_flit_i;
      tx_dec_d  = sam_flit_dec_i;
    end else begin
      rd_ptr_d  = rd_ptr_q;
      tx_v_d    = 1'b0;
    end

    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + FIFO_CNT_W'(1);
      2'b01:   cnt_d = cnt_q - FIFO_CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    case ({pop_s, rtn_ok_s})
      2'b10:   cred_d = cred_q - CRED_CNT_W'(1);
      2'b01:   cred_d = cred_q + CRED_CNT_W'(1);
      default: cred_d = cred_q;
    endcase
  end

  // Control and tx registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q  <= {PTR_W{1'b0}};
      rd_ptr_q  <= {PTR_W{1'b0}};
      cnt_q     <= {FIFO_CNT_W{1'b0}};
      cred_q    <= CRED_CNT_W'(ROUTER_CREDIT);
      tx_v_q    <= 1'b0;
      tx_flit_q <= '0;
      tx_dec_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      cred_q    <= cred_d;
      tx_v_q    <= tx_v_d;
      tx_flit_q <= tx_flit_d;
      tx_dec_q  <= tx_dec_d;
      err_q     <= err_d;
    end
  end

  // FIFO storage; not reset, contents are qualified by the occupancy count.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= rn_flit_i;
    end
  end

  assign rn_flit_rdy_o = ~full_s;
  assign sam_flit_v_o  = ~empty_s;
  assign sam_flit_o    = mem_q[rd_ptr_q];
  assign tx_flit_v_o   = tx_v_q;
  assign tx_flit_o     = tx_flit_q;
  assign tx_flit_dec_o = tx_dec_q;
  assign fifo_cnt_o    = cnt_q;
  assign credit_cnt_o  = cred_q;
  assign credit_err_o  = err_q;

  rn_inject_queue_chk u_chk (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .full_i  (full_s),
    .empty_i (empty_s)
  );

endmodule

// rn_inject_queue_chk
//   Protocol checker: the FIFO never accepts into a full buffer and never
//   pops an empty one.
// Ports: clk, rstn, push_i, pop_i, full_i, empty_i (internal handshakes).
module rn_inject_queue_chk (
  input logic clk,
  input logic rstn,
  input logic push_i,
  input logic pop_i,
  input logic full_i,
  input logic empty_i
);

  a_no_push_full: assert property (@(posedge clk) disable iff (!rstn) !(push_i && full_i));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rstn) !(pop_i && empty_i));

endmodule

// File: tb/tb_rn_inject_queue.sv
// Testbench for rn_inject_queue: the bench plays the RN agent, the SAM and
// the router credit return. Expected tx flits are queued at issue time and
// a negedge monitor compares every tx_flit_v_o beat against the queue.
module tb_rn_inject_queue;

  typedef struct packed {
    logic [1:0] x;
    logic [1:0] y;
    logic [1:0] port;
    logic       has_addr;
  } dec_t;

  typedef struct packed {
    logic [255:0] f;
    dec_t         d;
  } exp_t;

  logic         clk = 1'b0;
  logic         rstn;
  logic         rn_flit_v;
  logic [255:0] rn_flit;
  logic         rn_flit_rdy;
  logic         sam_flit_v;
  logic [255:0] sam_flit_o;
  logic [255:0] sam_flit_in;
  dec_t         sam_dec_in;
  logic         tx_v;
  logic [255:0] tx_flit;
  dec_t         tx_dec;
  logic         credit_rtn;
  logic [2:0]   fifo_cnt;
  logic [2:0]   credit_cnt;
  logic         credit_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int seq    = 0;
  exp_t exp_q [$];
  int   txc_q [$];

  // Hand-computed SAM targets for address (i+1)*0x40, 9 slices on a 3x3 mesh.
  logic [1:0] exp_x [16] = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2,
                             2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
  logic [1:0] exp_y [16] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2,
                             2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2};

  rn_inject_queue #(
    .flit_payload_t (logic [255:0]),
    .flit_dec_t     (dec_t),
    .FIFO_DEPTH     (4),
    .ROUTER_CREDIT  (4)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .rn_flit_v_i     (rn_flit_v),
    .rn_flit_i       (rn_flit),
    .rn_flit_rdy_o   (rn_flit_rdy),
    .sam_flit_v_o    (sam_flit_v),
    .sam_flit_o      (sam_flit_o),
    .sam_flit_i      (sam_flit_in),
    .sam_flit_dec_i  (sam_dec_in),
    .tx_flit_v_o     (tx_v),
    .tx_flit_o       (tx_flit),
    .tx_flit_dec_o   (tx_dec),
    .tx_credit_rtn_i (credit_rtn),
    .fifo_cnt_o      (fifo_cnt),
    .credit_cnt_o    (credit_cnt),
    .credit_err_o    (credit_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Bench SAM: slice = line address mod 9, node (x,y) = (slice%3, slice/3).
  logic [41:0] line_s;
  logic [3:0]  slice_s;
  logic [1:0]  sx_s, sy_s;
  always_comb begin
    line_s      = sam_flit_o[47:6];
    slice_s     = 4'(line_s % 42'd9);
    sx_s        = 2'(slice_s % 4'd3);
    sy_s        = 2'(slice_s / 4'd3);
    sam_dec_in  = {sx_s, sy_s, 2'd1, 1'b1};
    sam_flit_in = sam_flit_o;
    sam_flit_in[55:48] = {1'b0, sx_s, sy_s, 2'd1, 1'b1};
    sam_flit_in[63:56] = 8'h05;
  end

  // Monitor: every tx beat must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rstn && tx_v) begin
      txc_q.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL tx_unexpected: got flit tag %0h, expected no tx", tx_flit[71:64]);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (tx_flit !== e.f || tx_dec !== e.d) begin
          errors++;
          $display("FAIL tx_flit: got dec %0h flit %0h expected dec %0h flit %0h",
                   tx_dec, tx_flit[71:0], e.d, e.f[71:0]);
        end
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] mk_stim(input int idx, input int s);
    logic [255:0] f;
    f = '0;
    f[47:0]  = 48'(idx + 1) << 6;
    f[63:56] = 8'hAA;
    f[71:64] = 8'(s);
    return f;
  endfunction

  // Drive one accepted push and record the expected router-side flit.
  task automatic drive(input int idx);
    exp_t e;
    int   k;
    k = idx % 16;
    rn_flit_v = 1'b1;
    rn_flit   = mk_stim(k, seq);
    e.f       = rn_flit;
    e.f[55:48] = {1'b0, exp_x[k], exp_y[k], 2'd1, 1'b1};
    e.f[63:56] = 8'h05;
    e.d       = {exp_x[k], exp_y[k], 2'd1, 1'b1};
    exp_q.push_back(e);
    seq++;
    step();
  endtask

  initial begin
    rstn = 1'b0; rn_flit_v = 1'b0; rn_flit = '0; credit_rtn = 1'b0;
    step(); step();
    rstn = 1'b1;
    step();

    // Reset state
    chk("rst_fifo_cnt", 64'(fifo_cnt), 64'd0);
    chk("rst_credit", 64'(credit_cnt), 64'd4);
    chk("rst_rdy", 64'(rn_flit_rdy), 64'd1);
    chk("rst_tx_v", 64'(tx_v), 64'd0);
    chk("rst_err", 64'(credit_err), 64'd0);

    // Single flit, addr 0x40 -> node (1,0) port 1
    drive(0);
    rn_flit_v = 1'b0;
    chk("single_tx_early", 64'(tx_v), 64'd0);
    chk("single_head_v", 64'(sam_flit_v), 64'd1);
    step();
    chk("single_tx_v", 64'(tx_v), 64'd1);
    chk("single_dec", 64'(tx_dec), 64'(7'b01_00_01_1));
    step();
    chk("single_tx_pulse", 64'(tx_v), 64'd0);
    chk("single_credit", 64'(credit_cnt), 64'd3);
    chk("single_fifo", 64'(fifo_cnt), 64'd0);
    credit_rtn = 1'b1; step(); credit_rtn = 1'b0;
    chk("restore_credit", 64'(credit_cnt), 64'd4);

    // Six back-to-back pushes, no returns: four consecutive tx beats
    txc_q.delete();
    for (int i = 1; i < 7; i++) drive(i);
    rn_flit_v = 1'b0;
    repeat (4) step();
    chk("burst_tx_count", 64'(txc_q.size()), 64'd4);
    if (txc_q.size() == 4) chk("burst_consec", 64'(txc_q[3] - txc_q[0]), 64'd3);
    chk("burst_credit", 64'(credit_cnt), 64'd0);
    chk("burst_fifo", 64'(fifo_cnt), 64'd2);

    // One credit return releases exactly one more flit, next cycle
    txc_q.delete();
    credit_rtn = 1'b1; step(); credit_rtn = 1'b0;
    chk("rtn_tx_not_yet", 64'(tx_v), 64'd0);
    chk("rtn_credit_up", 64'(credit_cnt), 64'd1);
    step();
    chk("rtn_tx_v", 64'(tx_v), 64'd1);
    chk("rtn_credit", 64'(credit_cnt), 64'd0);
    chk("rtn_fifo", 64'(fifo_cnt), 64'd1);
    step();
    chk("rtn_tx_once", 64'(txc_q.size()), 64'd1);

    // Fill to full with no credit; a held 5th push is refused
    for (int i = 7; i < 10; i++) drive(i);
    chk("full_rdy", 64'(rn_flit_rdy), 64'd0);
    rn_flit_v = 1'b1;
    rn_flit   = mk_stim(10, 8'hEE);
    repeat (3) step();
    rn_flit_v = 1'b0;
    chk("full_fifo", 64'(fifo_cnt), 64'd4);
    chk("full_rdy_held", 64'(rn_flit_rdy), 64'd0);

    // Drain with continuous returns until credit is back at 4
    credit_rtn = 1'b1;
    repeat (8) step();
    credit_rtn = 1'b0;
    chk("drain_credit", 64'(credit_cnt), 64'd4);
    chk("drain_fifo", 64'(fifo_cnt), 64'd0);
    chk("drain_err", 64'(credit_err), 64'd0);
    chk("drain_pending", 64'(exp_q.size()), 64'd0);

    // Overflowing return: saturates and sets the sticky error
    credit_rtn = 1'b1; step(); credit_rtn = 1'b0;
    chk("ovf_credit", 64'(credit_cnt), 64'd4);
    chk("ovf_err", 64'(credit_err), 64'd1);
    step(); step();
    chk("ovf_err_sticky", 64'(credit_err), 64'd1);

    // Build up 3 queued flits with credit=1, then reset
    for (int i = 11; i < 14; i++) drive(i);
    rn_flit_v = 1'b0;
    step(); step();
    chk("pre_credit1", 64'(credit_cnt), 64'd1);
    chk("pre_fifo0", 64'(fifo_cnt), 64'd0);
    for (int i = 14; i < 18; i++) drive(i);
    rn_flit_v = 1'b0;
    chk("pre_fifo3", 64'(fifo_cnt), 64'd3);
    credit_rtn = 1'b1; step(); credit_rtn = 1'b0;
    chk("pre_rst_credit", 64'(credit_cnt), 64'd1);
    chk("pre_rst_fifo", 64'(fifo_cnt), 64'd3);
    chk("pre_rst_err", 64'(credit_err), 64'd1);
    rstn = 1'b0;
    step();
    exp_q.delete();
    chk("mid_rst_fifo", 64'(fifo_cnt), 64'd0);
    chk("mid_rst_credit", 64'(credit_cnt), 64'd4);
    chk("mid_rst_tx_v", 64'(tx_v), 64'd0);
    chk("mid_rst_err", 64'(credit_err), 64'd0);
    chk("mid_rst_tx_flit", tx_flit[63:0], 64'd0);
    chk("mid_rst_tx_dec", 64'(tx_dec), 64'd0);
    rstn = 1'b1;
    step(); step();
    chk("post_rst_idle_tx", 64'(tx_v), 64'd0);
    chk("post_rst_rdy", 64'(rn_flit_rdy), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
